// File: rtl/ready_ctl_pkg.sv
// Shared types and constants for the 6502 READY / DMA arbiter.
// Holds the arbiter state encoding, counter widths and the burst counter width helper.
package ready_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HALT_PEND,
    DMA,
    RELEASE
  } state_e;

  localparam int CNT_W_COOL = 8;
  localparam int CNT_W_WAIT = 4;

  // Unlimited bursts (0) still need a 1-bit counter so the port stays legal.
  function automatic int burst_w(input int max_burst);
    int w;
    w = (max_burst == 0) ? 1 : $clog2(max_burst + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ready_burst_timer.sv
// Burst length counter and post-release CPU cool-down counter for dma_ready_arbiter.
// burst_last flags the final permitted DMA cycle; cool_zero gates new DMA requests.
module ready_burst_timer
  import ready_ctl_pkg::*;
#(
  parameter int MAX_BURST      = 16,
  parameter int MIN_CPU_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic burst_clr,
  input  logic burst_inc,
  input  logic cool_load,
  input  logic cool_dec,
  output logic burst_last,
  output logic cool_zero
);

  localparam int BURST_W = burst_w(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_END = BURST_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
  localparam logic [CNT_W_COOL-1:0] COOL_LOAD = CNT_W_COOL'(MIN_CPU_CYCLES);

  logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [CNT_W_COOL-1:0] cool_cnt_q, cool_cnt_d;

  // An unlimited burst never advances the counter, so it cannot wrap.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (burst_clr) begin
      burst_cnt_d = '0;
    end else if (burst_inc && (MAX_BURST != 0)) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end
  end

  always_comb begin
    cool_cnt_d = cool_cnt_q;
    if (cool_load) begin
      cool_cnt_d = COOL_LOAD;
    end else if (cool_dec && (cool_cnt_q != '0)) begin
      cool_cnt_d = cool_cnt_q - CNT_W_COOL'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt_q <= '0;
      cool_cnt_q  <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
    end
  end

  assign burst_last = (MAX_BURST != 0) && (burst_cnt_q == BURST_END);
  assign cool_zero  = (cool_cnt_q == '0);

endmodule

// File: rtl/dma_ready_arbiter.sv
// Shares the 6502 bus with one DMA master by owning READY; grants only after the core halts.
// Optional slow-device wait states are built when WAIT_STATE_EN is defined.
module dma_ready_arbiter
  import ready_ctl_pkg::*;
#(
  parameter int MAX_BURST      = 16,
  parameter int MIN_CPU_CYCLES = 4,
  parameter int WAIT_STATES    = 1
) (
  input  logic clk_2,
  input  logic reset,
  input  logic rw_n,
  input  logic slow_next,
  input  logic dma_req,
  output logic READY,
  output logic dma_grant,
  output logic cpu_halted
);

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   dma_grant_q, dma_grant_d;
  logic   cpu_halted_q, cpu_halted_d;
  logic   burst_clr, burst_inc, cool_load, cool_dec;
  logic   burst_last, cool_zero;

`ifdef WAIT_STATE_EN
  localparam logic [CNT_W_WAIT-1:0] WAIT_LOAD = CNT_W_WAIT'(WAIT_STATES - 1);
  logic [CNT_W_WAIT-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic [CNT_W_WAIT:0] unused_cfg;
  assign unused_cfg = {slow_next, CNT_W_WAIT'(WAIT_STATES)};
`endif

  ready_burst_timer #(
    .MAX_BURST      (MAX_BURST),
    .MIN_CPU_CYCLES (MIN_CPU_CYCLES)
  ) u_timer (
    .clk        (clk_2),
    .reset      (reset),
    .burst_clr  (burst_clr),
    .burst_inc  (burst_inc),
    .cool_load  (cool_load),
    .cool_dec   (cool_dec),
    .burst_last (burst_last),
    .cool_zero  (cool_zero)
  );

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    dma_grant_d  = dma_grant_q;
    cpu_halted_d = cpu_halted_q;
    burst_clr    = 1'b0;
    burst_inc    = 1'b0;
    cool_load    = 1'b0;
    cool_dec     = 1'b0;
`ifdef WAIT_STATE_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        cool_dec = 1'b1;
        if (dma_req && cool_zero) begin
          state_d = HALT_PEND;
          ready_d = 1'b0;
`ifdef WAIT_STATE_EN
        end else if (slow_next) begin
          state_d    = WAIT;
          ready_d    = 1'b0;
          wait_cnt_d = WAIT_LOAD;
`endif
        end
      end
`ifdef WAIT_STATE_EN
      WAIT: begin
        cool_dec = 1'b1;
        if (wait_cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W_WAIT'(1);
        end
      end
`endif
      // Writes are not stalled by the core, so keep waiting until a read cycle is seen.
      HALT_PEND: begin
        if (!dma_req) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else if (rw_n) begin
          state_d      = DMA;
          dma_grant_d  = 1'b1;
          cpu_halted_d = 1'b1;
          burst_clr    = 1'b1;
        end
      end
      DMA: begin
        burst_inc = 1'b1;
        if (!dma_req || burst_last) begin
          state_d     = RELEASE;
          dma_grant_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d      = IDLE;
        ready_d      = 1'b1;
        cpu_halted_d = 1'b0;
        cool_load    = 1'b1;
      end
      default: begin
        state_d      = IDLE;
        ready_d      = 1'b1;
        dma_grant_d  = 1'b0;
        cpu_halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      dma_grant_q  <= 1'b0;
      cpu_halted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      dma_grant_q  <= dma_grant_d;
      cpu_halted_q <= cpu_halted_d;
    end
  end

`ifdef WAIT_STATE_EN
  always_ff @(posedge clk_2) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign READY      = ready_q;
  assign dma_grant  = dma_grant_q;
  assign cpu_halted = cpu_halted_q;

endmodule

// File: tb/tb_dma_ready_arbiter.sv
// Randomized and directed bench for dma_ready_arbiter against a cycle-level behavioural model.
// Honours WAIT_STATE_EN the same way the design does.
module tb_dma_ready_arbiter;

  localparam int MAX_BURST = 16;
  localparam int MIN_CPU   = 4;
  localparam int WAIT_ST   = 2;
`ifdef WAIT_STATE_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk_2 = 1'b0;
  logic reset, rw_n, slow_next, dma_req;
  logic READY, dma_grant, cpu_halted;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: booleans/counters describing what the core and DMA are doing.
  int stall_left = 0;   // remaining slow-device stall cycles
  bit halting    = 1'b0;
  int grant_n    = -1;  // grant cycles completed, -1 when DMA not owning bus
  bit releasing  = 1'b0;
  int gap        = 0;   // CPU cycles still owed before DMA may ask again

  dma_ready_arbiter #(
    .MAX_BURST      (MAX_BURST),
    .MIN_CPU_CYCLES (MIN_CPU),
    .WAIT_STATES    (WAIT_ST)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .rw_n       (rw_n),
    .slow_next  (slow_next),
    .dma_req    (dma_req),
    .READY      (READY),
    .dma_grant  (dma_grant),
    .cpu_halted (cpu_halted)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input bit s, input bit d);
    if (r) begin
      stall_left = 0; halting = 0; grant_n = -1; releasing = 0; gap = 0;
    end else if (releasing) begin
      releasing = 0;
      gap = MIN_CPU;
    end else if (grant_n >= 0) begin
      grant_n++;
      if (!d || (MAX_BURST != 0 && grant_n == MAX_BURST)) begin
        grant_n = -1;
        releasing = 1;
      end
    end else if (halting) begin
      if (!d) halting = 0;
      else if (w) begin
        halting = 0;
        grant_n = 0;
      end
    end else if (stall_left > 0) begin
      stall_left--;
      if (gap > 0) gap--;
    end else begin
      if (d && gap == 0) halting = 1;
      else if (WAIT_EN && s) stall_left = WAIT_ST;
      if (gap > 0) gap--;
    end
  endtask

  task automatic cyc(input bit r, input bit w, input bit s, input bit d);
    logic prev_grant;
    bit   exp_ready, exp_grant, exp_halt;
    prev_grant = dma_grant;
    reset = r; rw_n = w; slow_next = s; dma_req = d;
    @(posedge clk_2);
    model_step(r, w, s, d);
    #1;
    exp_grant = (grant_n >= 0);
    exp_halt  = exp_grant || releasing;
    exp_ready = !(stall_left > 0 || halting || exp_halt);
    chk("READY", 32'(READY), 32'(exp_ready));
    chk("dma_grant", 32'(dma_grant), 32'(exp_grant));
    chk("cpu_halted", 32'(cpu_halted), 32'(exp_halt));
    chk("ready_grant_excl", 32'(READY & dma_grant), 32'd0);
    if (dma_grant === 1'b1 && prev_grant === 1'b0 && !r)
      chk("grant_rise_rw", 32'(w), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
  endtask

  initial begin
    bit d_lvl;
    reset = 1'b1; rw_n = 1'b1; slow_next = 1'b0; dma_req = 1'b0;

    // Reset state
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("reset_ready", 32'(READY), 32'd1);
    chk("reset_grant", 32'(dma_grant), 32'd0);
    idle(2);

    // Halt on a read, grant after two edges, hold, drop, release
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 1);
    idle(8);

    // Three pending writes delay the grant
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("grant_after_writes", 32'(dma_grant), 32'd0);
    cyc(0, 1, 0, 1);
    chk("grant_on_read", 32'(dma_grant), 32'd1);
    idle(8);

    // Long request: burst limit, release, cool-down, re-halt
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 1);
    idle(8);

    // Abort in HALT_PEND while writes are pending
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("abort_ready", 32'(READY), 32'd1);
    idle(3);

    // Slow access, then slow access coinciding with a DMA request
    cyc(0, 1, 1, 0);
    idle(4);
    cyc(0, 1, 1, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    idle(6);

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1);
    cyc(1, 1, 0, 1);
    chk("rst_mid_grant", 32'(dma_grant), 32'd0);
    chk("rst_mid_halt", 32'(cpu_halted), 32'd0);
    cyc(1, 1, 0, 1);
    idle(4);

    // Randomized traffic
    d_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) d_lvl = ~d_lvl;
      cyc(($urandom_range(299) == 0), ($urandom_range(3) != 0),
          ($urandom_range(5) == 0), d_lvl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
